// File: rtl/wt_fetch_seq.sv
// wt_fetch_seq: read-side sequencer for a dual-port, synchronous-read weight ROM.
// A start command walks `len` words from `base_addr`, two words per issue
// (port A takes the even offset, port B the odd offset). Addresses wrap modulo DEPTH.
// The resulting word pairs stream out over a valid/ready interface.
// Returning ROM data lands in a registered output stage backed by a 2-entry skid
// FIFO. Issue credits cover every read still in flight, so data is never dropped.
// Optional feature macro: WT_FETCH_CHECK_EN. It adds command range checking and
// the cmd_err port.
module wt_fetch_seq #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 144,
  parameter int DEPTH      = 76
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  input  logic [DATA_WIDTH-1:0] mem_q_a,
  input  logic [DATA_WIDTH-1:0] mem_q_b,
  output logic                  wt_valid,
  input  logic                  wt_ready,
  output logic [DATA_WIDTH-1:0] wt_data_a,
  output logic [DATA_WIDTH-1:0] wt_data_b,
  output logic                  wt_b_valid,
  output logic                  wt_last
`ifdef WT_FETCH_CHECK_EN
  ,
  output logic                  cmd_err
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_W   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] TWO_W   = {{(ADDR_WIDTH-1){1'b0}}, 2'b10};

  // Add a small increment to an in-range address, wrapping with a compare-subtract
  // so that non-power-of-two depths wrap correctly (e.g. 75 + 1 -> 0 for 76).
  function automatic logic [ADDR_WIDTH-1:0] wrap_add(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [ADDR_WIDTH:0]   inc);
    logic [ADDR_WIDTH:0] s;
    s = {1'b0, a} + inc;
    if (s >= DEPTH_W) begin
      s = s - DEPTH_W;
    end else begin
      s = s;
    end
    return s[ADDR_WIDTH-1:0];
  endfunction

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;

  // Read pipeline: iss = address registered, cap = ROM data present on mem_q.
  logic iss_q, iss_bv_q, iss_last_q;
  logic cap_q, cap_bv_q, cap_last_q;

  // Skid FIFO behind the output stage.
  logic [DATA_WIDTH-1:0] f_a_q [2];
  logic [DATA_WIDTH-1:0] f_b_q [2];
  logic [1:0]            f_bv_q, f_last_q;
  logic                  f_rd_q, f_wr_q;
  logic [1:0]            f_cnt_q;

  // Registered output stage.
  logic                  ov_q, obv_q, ol_q;
  logic [DATA_WIDTH-1:0] oa_q, ob_q;

  logic                  cmd_ok_s, start_acc_s, issue_s, pop_s;
  logic                  load_out_s, fifo_pop_s, bypass_s, fifo_push_s;
  logic [2:0]            total_s;
  logic [DATA_WIDTH-1:0] cap_b_s;

`ifdef WT_FETCH_CHECK_EN
  logic cmd_err_q;
  assign cmd_ok_s = (len != {(ADDR_WIDTH+1){1'b0}}) && (len <= DEPTH_W) &&
                    ({1'b0, base_addr} < DEPTH_W);
  assign cmd_err  = cmd_err_q;
`else
  assign cmd_ok_s = (len != {(ADDR_WIDTH+1){1'b0}});
`endif

  assign start_acc_s = start && (state_q == ST_IDLE) && cmd_ok_s;
  assign pop_s       = ov_q && wt_ready;

  // Held beats plus reads still in flight may never exceed the storage available
  // (output stage + two skid entries). A pop in the same cycle frees one slot.
  assign total_s = {2'b00, ov_q} + {1'b0, f_cnt_q} + {2'b00, iss_q} + {2'b00, cap_q};
  assign issue_s = (state_q == ST_FETCH) && ((total_s < 3'd3) || pop_s);

  assign load_out_s  = !ov_q || pop_s;
  assign fifo_pop_s  = load_out_s && (f_cnt_q != 2'd0);
  assign bypass_s    = load_out_s && (f_cnt_q == 2'd0) && cap_q;
  assign fifo_push_s = cap_q && !bypass_s;
  assign cap_b_s     = cap_bv_q ? mem_q_b : {DATA_WIDTH{1'b0}};

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DRAIN) && pop_s && ol_q;
  assign mem_addr_a = addr_a_q;
  assign mem_addr_b = addr_b_q;
  assign wt_valid   = ov_q;
  assign wt_data_a  = oa_q;
  assign wt_data_b  = ob_q;
  assign wt_b_valid = obv_q;
  assign wt_last    = ol_q;

  // Next-state logic for the run FSM, walk pointer and remaining word count.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc_s) begin
          state_d = ST_FETCH;
          ptr_d   = base_addr;
          rem_d   = len;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (issue_s) begin
          ptr_d = wrap_add(ptr_q, TWO_W);
          if (rem_q > TWO_W) begin
            rem_d   = rem_q - TWO_W;
            state_d = ST_FETCH;
          end else begin
            rem_d   = {(ADDR_WIDTH+1){1'b0}};
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (pop_s && ol_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Run FSM, pointer and remaining-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= {ADDR_WIDTH{1'b0}};
      rem_q   <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  // ROM address registers plus the tag pipeline that tracks reads in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_a_q   <= {ADDR_WIDTH{1'b0}};
      addr_b_q   <= {ADDR_WIDTH{1'b0}};
      iss_q      <= 1'b0;
      iss_bv_q   <= 1'b0;
      iss_last_q <= 1'b0;
      cap_q      <= 1'b0;
      cap_bv_q   <= 1'b0;
      cap_last_q <= 1'b0;
    end else begin
      if (issue_s) begin
        addr_a_q   <= ptr_q;
        addr_b_q   <= wrap_add(ptr_q, ONE_W);
        iss_bv_q   <= (rem_q >= TWO_W);
        iss_last_q <= (rem_q <= TWO_W);
      end
      iss_q      <= issue_s;
      cap_q      <= iss_q;
      cap_bv_q   <= iss_bv_q;
      cap_last_q <= iss_last_q;
    end
  end

  // Skid FIFO: absorbs returning ROM data when the output stage cannot take it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        f_a_q[i] <= {DATA_WIDTH{1'b0}};
        f_b_q[i] <= {DATA_WIDTH{1'b0}};
      end
      f_bv_q   <= 2'b00;
      f_last_q <= 2'b00;
      f_rd_q   <= 1'b0;
      f_wr_q   <= 1'b0;
      f_cnt_q  <= 2'd0;
    end else begin
      if (fifo_push_s) begin
        f_a_q[f_wr_q]    <= mem_q_a;
        f_b_q[f_wr_q]    <= cap_b_s;
        f_bv_q[f_wr_q]   <= cap_bv_q;
        f_last_q[f_wr_q] <= cap_last_q;
        f_wr_q           <= ~f_wr_q;
      end
      if (fifo_pop_s) begin
        f_rd_q <= ~f_rd_q;
      end
      case ({fifo_push_s, fifo_pop_s})
        2'b10:   f_cnt_q <= f_cnt_q + 2'd1;
        2'b01:   f_cnt_q <= f_cnt_q - 2'd1;
        default: f_cnt_q <= f_cnt_q;
      endcase
    end
  end

  // Output stage: refilled from the FIFO head first, else straight from the ROM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q  <= 1'b0;
      oa_q  <= {DATA_WIDTH{1'b0}};
      ob_q  <= {DATA_WIDTH{1'b0}};
      obv_q <= 1'b0;
      ol_q  <= 1'b0;
    end else if (load_out_s) begin
      if (fifo_pop_s) begin
        ov_q  <= 1'b1;
        oa_q  <= f_a_q[f_rd_q];
        ob_q  <= f_b_q[f_rd_q];
        obv_q <= f_bv_q[f_rd_q];
        ol_q  <= f_last_q[f_rd_q];
      end else if (bypass_s) begin
        ov_q  <= 1'b1;
        oa_q  <= mem_q_a;
        ob_q  <= cap_b_s;
        obv_q <= cap_bv_q;
        ol_q  <= cap_last_q;
      end else begin
        ov_q  <= 1'b0;
        oa_q  <= {DATA_WIDTH{1'b0}};
        ob_q  <= {DATA_WIDTH{1'b0}};
        obv_q <= 1'b0;
        ol_q  <= 1'b0;
      end
    end
  end

`ifdef WT_FETCH_CHECK_EN
  // One-cycle error pulse for every out-of-range start seen while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= start && (state_q == ST_IDLE) && !cmd_ok_s;
    end
  end
`endif

endmodule

// File: tb/tb_wt_fetch_seq.sv
// Scoreboard bench for wt_fetch_seq: expected beats come from a word-level
// model of the run (modulo-DEPTH word indices into a random ROM image). A
// negedge monitor checks every accepted beat, the done pulse and stall stability.
module tb_wt_fetch_seq;
  localparam int AW    = 7;
  localparam int DW    = 144;
  localparam int DEPTH = 76;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          bv;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [DW-1:0] mem_q_a, mem_q_b;
  logic          wt_valid, wt_ready;
  logic [DW-1:0] wt_data_a, wt_data_b;
  logic          wt_b_valid, wt_last;
`ifdef WT_FETCH_CHECK_EN
  logic          cmd_err;
`endif

  logic [DW-1:0] rom [DEPTH];
  beat_t         exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            beats_seen = 0;
  int            done_seen = 0;
  int            runs_expected = 0;
  int            ready_mode = 0;

  wt_fetch_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_q_a(mem_q_a), .mem_q_b(mem_q_b), .wt_valid(wt_valid), .wt_ready(wt_ready),
    .wt_data_a(wt_data_a), .wt_data_b(wt_data_b), .wt_b_valid(wt_b_valid),
    .wt_last(wt_last)
`ifdef WT_FETCH_CHECK_EN
    ,
    .cmd_err(cmd_err)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read ROM with one cycle of latency.
  always @(posedge clk) begin
    mem_q_a <= rom[mem_addr_a];
    mem_q_b <= rom[mem_addr_b];
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: a run is ceil(len/2) beats of word indices (base+2k) mod DEPTH.
  task automatic push_run(input int b, input int l);
    int nb;
    beat_t e;
    nb = (l + 1) / 2;
    for (int k = 0; k < nb; k++) begin
      e.bv   = (2 * k + 1 < l);
      e.a    = rom[(b + 2 * k) % DEPTH];
      e.b    = e.bv ? rom[(b + 2 * k + 1) % DEPTH] : '0;
      e.last = (k == nb - 1);
      exp_q.push_back(e);
    end
    runs_expected++;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the start edge.
  task automatic start_cmd(input int b, input int l, input bit expect_run);
    start     = 1'b1;
    base_addr = b[AW-1:0];
    len       = l[AW:0];
    if (expect_run) push_run(b, l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk(name, ok, 1'b1);
  endtask

  // wt_ready generator: always 1, the 1,0,0,1 pattern, or random.
  initial begin
    int tcnt;
    tcnt = 0;
    wt_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1: begin
          wt_ready = ((tcnt % 4) == 0) || ((tcnt % 4) == 3);
          tcnt++;
        end
        2:       wt_ready = ($urandom % 4) != 0;
        default: wt_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted beat and checks stall stability.
  initial begin
    beat_t e, snap;
    bit    stall_prev;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", wt_valid, 1'b1);
          chk("stall_data_a", wt_data_a, snap.a);
          chk("stall_data_b", wt_data_b, snap.b);
          chk("stall_bv", wt_b_valid, snap.bv);
          chk("stall_last", wt_last, snap.last);
        end
        if (wt_valid && wt_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got data_a %h expected no beat", wt_data_a);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data_a", wt_data_a, e.a);
            chk("beat_data_b", wt_data_b, e.b);
            chk("beat_b_valid", wt_b_valid, e.bv);
            chk("beat_last", wt_last, e.last);
            chk("beat_done", done, e.last);
          end
          beats_seen++;
        end
        if (done) done_seen++;
        stall_prev = wt_valid && !wt_ready;
        snap.a    = wt_data_a;
        snap.b    = wt_data_b;
        snap.bv   = wt_b_valid;
        snap.last = wt_last;
      end
    end
  end

  initial begin
    logic [159:0]  tmp;
    logic [AW-1:0] a0;
    int            b0, d0;
    bit            got;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tmp    = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rom[i] = tmp[DW-1:0];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", wt_valid, 1'b0);
    chk("rst_bv", wt_b_valid, 1'b0);
    chk("rst_last", wt_last, 1'b0);
    chk("rst_addr_a", mem_addr_a, '0);
    chk("rst_addr_b", mem_addr_b, '0);
    chk("rst_data_a", wt_data_a, '0);
    chk("rst_data_b", wt_data_b, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // len == 0 is never started.
    start_cmd(5, 0, 1'b0);
    chk("len0_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("len0_addr_a", mem_addr_a, '0);
    chk("len0_valid", wt_valid, 1'b0);

    // Test 1: base 0, len 4 -- address pairs and first-beat latency.
    ready_mode = 0;
    start_cmd(0, 4, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_valid_n0", wt_valid, 1'b0);
    @(posedge clk); #1;
    chk("t1_addr_a0", mem_addr_a, 7'd0);
    chk("t1_addr_b0", mem_addr_b, 7'd1);
    chk("t1_valid_n1", wt_valid, 1'b0);
    @(posedge clk); #1;
    chk("t1_addr_a1", mem_addr_a, 7'd2);
    chk("t1_addr_b1", mem_addr_b, 7'd3);
    chk("t1_valid_n2", wt_valid, 1'b0);
    @(posedge clk); #1;
    chk("t1_valid_n3", wt_valid, 1'b1);
    wait_idle("t1_complete");

    // Test 2: base 10, len 5 -- odd tail beat.
    b0 = beats_seen;
    start_cmd(10, 5, 1'b1);
    wait_idle("t2_complete");
    chk("t2_beats", beats_seen - b0, 3);

    // Test 3: base 74, len 4 -- wrap at DEPTH.
    start_cmd(74, 4, 1'b1);
    @(posedge clk); #1;
    chk("t3_addr_a0", mem_addr_a, 7'd74);
    chk("t3_addr_b0", mem_addr_b, 7'd75);
    @(posedge clk); #1;
    chk("t3_addr_a1", mem_addr_a, 7'd0);
    chk("t3_addr_b1", mem_addr_b, 7'd1);
    wait_idle("t3_complete");

    // Test 4: base 0, len 8 under the 1,0,0,1 ready pattern.
    ready_mode = 1;
    b0 = beats_seen;
    start_cmd(0, 8, 1'b1);
    wait_idle("t4_complete");
    chk("t4_beats", beats_seen - b0, 4);

    // Test 5: reset in the middle of a run.
    ready_mode = 0;
    b0 = beats_seen;
    start_cmd(0, 8, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (beats_seen > b0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t5_first_beat", got, 1'b1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_valid", wt_valid, 1'b0);
    chk("t5_last", wt_last, 1'b0);
    chk("t5_addr_a", mem_addr_a, '0);
    chk("t5_data_a", wt_data_a, '0);
    exp_q.delete();
    runs_expected--;
    d0 = done_seen;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_done", done_seen, d0);
    chk("t5_idle", busy, 1'b0);
    start_cmd(5, 7, 1'b1);
    wait_idle("t5_restart_complete");

`ifdef WT_FETCH_CHECK_EN
    // Test 6: out-of-range commands are rejected with a cmd_err pulse.
    a0 = mem_addr_a;
    start_cmd(76, 4, 1'b0);
    chk("t6_err_base", cmd_err, 1'b1);
    chk("t6_busy_base", busy, 1'b0);
    @(posedge clk); #1;
    chk("t6_err_pulse", cmd_err, 1'b0);
    chk("t6_addr_hold", mem_addr_a, a0);
    start_cmd(0, 77, 1'b0);
    chk("t6_err_len", cmd_err, 1'b1);
    chk("t6_busy_len", busy, 1'b0);
    @(posedge clk); #1;
`endif

    // Random commands under random backpressure.
    ready_mode = 2;
    for (int r = 0; r < 25; r++) begin
      start_cmd($urandom_range(0, DEPTH - 1), $urandom_range(1, DEPTH), 1'b1);
      wait_idle("rand_complete");
    end

    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_seen, runs_expected);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
